// File: rtl/key_mode_if.sv
// Key inputs plus command/indicator outputs exchanged between the key front end
// (master) and key_mode_ctrl (slave).
interface key_mode_if #(
  parameter int KEY_W   = 8,
  parameter int MODE_W  = 2,
  parameter int FIELD_W = 2
);
  logic [KEY_W-1:0]   KEY;
  logic               ALARM_RING;
  logic [MODE_W-1:0]  MODE;
  logic               EDIT;
  logic [FIELD_W-1:0] FIELD;
  logic               INC;
  logic               DEC;
  logic               COMMIT;
  logic               ABORT;
  logic               ALARM_OFF;
  logic               MERIDIAN_TOGGLE;
  logic [7:0]         out_MERIDIAN;

  modport master (
    output KEY, ALARM_RING,
    input  MODE, EDIT, FIELD, INC, DEC, COMMIT, ABORT, ALARM_OFF,
           MERIDIAN_TOGGLE, out_MERIDIAN
  );

  modport slave (
    input  KEY, ALARM_RING,
    output MODE, EDIT, FIELD, INC, DEC, COMMIT, ABORT, ALARM_OFF,
           MERIDIAN_TOGGLE, out_MERIDIAN
  );
endinterface

// File: rtl/key_mode_ctrl.sv
// View/edit key controller: mode stepping, field cursor, up/down auto-repeat,
// edit timeout and alarm-dismiss priority, all outputs registered.
module key_mode_ctrl #(
  parameter int KEY_W       = 8,
  parameter int NUM_MODES   = 4,
  parameter int NUM_FIELDS  = 3,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100,
  parameter int TIMEOUT     = 10000
) (
  input  logic      CLK,
  input  logic      RESETN,
  key_mode_if.slave bus
);
  localparam int MODE_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int FIELD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  localparam int K_DOWN   = 0;
  localparam int K_UP     = 1;
  localparam int K_CANCEL = 2;
  localparam int K_SET    = 3;
  localparam int K_MENU   = 4;

  localparam logic [MODE_W-1:0]  MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(NUM_FIELDS - 1);
  localparam logic [7:0]         MER_AM     = 8'h41;
  localparam logic [7:0]         MER_PM     = 8'h50;

  typedef enum logic {ST_VIEW = 1'b0, ST_EDIT = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [4:0]         keys, keys_q_reg, press, rpt_mask;
  logic               press_valid, alarm, cmd_ok;
  logic               hold_ok, rpt_due, rpt_pulse, to_expire;
  logic               unused_keys;

  logic [MODE_W-1:0]  mode_reg, mode_next;
  logic [FIELD_W-1:0] field_reg, field_next;
  logic [7:0]         meridian_reg, meridian_next;
  logic               inc_reg, inc_next, dec_reg, dec_next;
  logic               commit_reg, commit_next, abort_reg, abort_next;
  logic               alarm_off_reg, alarm_off_next, mtog_reg, mtog_next;
  logic               rpt_active_reg, rpt_active_next, rpt_up_reg, rpt_up_next;
  logic [RPT_W-1:0]   rpt_cnt_reg, rpt_cnt_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;

  // Only the top five key bits carry meaning; the rest are folded away.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_keymap
      assign keys[gi] = bus.KEY[KEY_W-5+gi];
    end
  endgenerate
  assign unused_keys = ^bus.KEY;

  assign alarm = bus.ALARM_RING;
  assign press = keys & ~keys_q_reg;
  // Exactly one mapped key rising and nothing else held.
  assign press_valid = (press != 5'd0) && ((press & (press - 5'd1)) == 5'd0) && (keys == press);
  assign cmd_ok      = press_valid && !alarm;

  assign rpt_mask  = rpt_up_reg ? 5'b00010 : 5'b00001;
  assign hold_ok   = rpt_active_reg && (state_reg == ST_EDIT) && (keys == rpt_mask);
  assign rpt_due   = hold_ok && (rpt_cnt_reg == RPT_W'(1));
  assign rpt_pulse = rpt_due && !alarm;
  assign to_expire = (state_reg == ST_EDIT) && !press_valid && !rpt_pulse &&
                     (to_cnt_reg == TO_W'(1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg      <= ST_VIEW;
      keys_q_reg     <= '0;
      mode_reg       <= '0;
      field_reg      <= '0;
      meridian_reg   <= MER_AM;
      inc_reg        <= 1'b0;
      dec_reg        <= 1'b0;
      commit_reg     <= 1'b0;
      abort_reg      <= 1'b0;
      alarm_off_reg  <= 1'b0;
      mtog_reg       <= 1'b0;
      rpt_active_reg <= 1'b0;
      rpt_up_reg     <= 1'b0;
      rpt_cnt_reg    <= '0;
      to_cnt_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      keys_q_reg     <= keys;
      mode_reg       <= mode_next;
      field_reg      <= field_next;
      meridian_reg   <= meridian_next;
      inc_reg        <= inc_next;
      dec_reg        <= dec_next;
      commit_reg     <= commit_next;
      abort_reg      <= abort_next;
      alarm_off_reg  <= alarm_off_next;
      mtog_reg       <= mtog_next;
      rpt_active_reg <= rpt_active_next;
      rpt_up_reg     <= rpt_up_next;
      rpt_cnt_reg    <= rpt_cnt_next;
      to_cnt_reg     <= to_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_VIEW: begin
        if (cmd_ok && press[K_SET]) state_next = ST_EDIT;
      end
      ST_EDIT: begin
        if ((cmd_ok && (press[K_CANCEL] || (press[K_SET] && field_reg == FIELD_LAST))) ||
            to_expire)
          state_next = ST_VIEW;
      end
      default: state_next = ST_VIEW;
    endcase
  end

  always_comb begin
    mode_next       = mode_reg;
    field_next      = field_reg;
    meridian_next   = meridian_reg;
    inc_next        = 1'b0;
    dec_next        = 1'b0;
    commit_next     = 1'b0;
    abort_next      = 1'b0;
    alarm_off_next  = 1'b0;
    mtog_next       = 1'b0;
    rpt_active_next = 1'b0;
    rpt_up_next     = rpt_up_reg;
    rpt_cnt_next    = '0;
    to_cnt_next     = '0;

    // A ringing alarm swallows the press entirely.
    if (press_valid && alarm) begin
      alarm_off_next = 1'b1;
    end else if (cmd_ok && state_reg == ST_VIEW) begin
      if (press[K_MENU])
        mode_next = (mode_reg == MODE_LAST) ? '0 : mode_reg + 1'b1;
      if (press[K_SET])
        field_next = '0;
      if (press[K_CANCEL] && mode_reg == '0) begin
        meridian_next = (meridian_reg == MER_AM) ? MER_PM : MER_AM;
        mtog_next     = 1'b1;
      end
    end else if (cmd_ok) begin
      if (press[K_SET]) begin
        if (field_reg == FIELD_LAST) begin
          commit_next = 1'b1;
          field_next  = '0;
        end else begin
          field_next = field_reg + 1'b1;
        end
      end
      if (press[K_CANCEL]) begin
        abort_next = 1'b1;
        field_next = '0;
      end
      inc_next = press[K_UP];
      dec_next = press[K_DOWN];
    end

    // Hold counter: loaded at the initial press, reloaded at each due point.
    if (cmd_ok && state_reg == ST_EDIT && (press[K_UP] || press[K_DOWN])) begin
      rpt_active_next = 1'b1;
      rpt_up_next     = press[K_UP];
      rpt_cnt_next    = RPT_W'(REPEAT_DLY);
    end else if (hold_ok) begin
      rpt_active_next = 1'b1;
      if (rpt_due) begin
        rpt_cnt_next = RPT_W'(REPEAT_RATE);
        inc_next     = inc_next | (rpt_pulse && rpt_up_reg);
        dec_next     = dec_next | (rpt_pulse && !rpt_up_reg);
      end else begin
        rpt_cnt_next = rpt_cnt_reg - 1'b1;
      end
    end

    if (to_expire) begin
      abort_next = 1'b1;
      field_next = '0;
    end
    if (state_next == ST_EDIT) begin
      if (state_reg == ST_VIEW || press_valid || rpt_pulse)
        to_cnt_next = TO_W'(TIMEOUT);
      else
        to_cnt_next = to_cnt_reg - 1'b1;
    end
  end

  assign bus.MODE            = mode_reg;
  assign bus.EDIT            = (state_reg == ST_EDIT);
  assign bus.FIELD           = field_reg;
  assign bus.INC             = inc_reg;
  assign bus.DEC             = dec_reg;
  assign bus.COMMIT          = commit_reg;
  assign bus.ABORT           = abort_reg;
  assign bus.ALARM_OFF       = alarm_off_reg;
  assign bus.MERIDIAN_TOGGLE = mtog_reg;
  assign bus.out_MERIDIAN    = meridian_reg;
endmodule

// File: doc/key_mode_ctrl.md
Name: key_mode_ctrl

Overview:
- Clocked, parametrised successor to the combinational key decoder in the alarm-clock RTL.
- Takes debounced one-hot KEY levels and runs a view/edit state machine with a wrapping mode index, a field cursor, and up/down auto-repeat.
- Adds edit timeout and alarm-dismiss priority.
- Sits between the key debouncer and the time/alarm counter blocks. It drives their single-cycle command pulses and the meridian indicator.

Parameters:
- KEY_W, 8: KEY bus width. Key map: MENU=bit KEY_W-1, SET=KEY_W-2, CANCEL=KEY_W-3, UP=KEY_W-4, DOWN=KEY_W-5. Remaining bits are unused and ignored.
- NUM_MODES, 4: number of display modes (0 = current time, 1 = alarm time, others user-defined). Must be ≥2.
- NUM_FIELDS, 3: editable fields per mode (0 = hour, 1 = minute, 2 = second). Must be ≥1.
- REPEAT_DLY, 500: cycles UP/DOWN must be held before auto-repeat starts. Must be ≥1.
- REPEAT_RATE, 100: cycles between auto-repeat pulses. Must be ≥1.
- TIMEOUT, 10000: idle cycles in EDIT before automatic abort. Must be ≥2.

Ports:
- CLK, input, 1: system clock; all state changes on the rising edge.
- RESETN, input, 1: asynchronous, active-low reset.
- KEY, input, KEY_W: debounced key levels, active high, synchronous to CLK.
- ALARM_RING, input, 1: level, high while the alarm is sounding.
- MODE, output, $clog2(NUM_MODES): current mode index.
- EDIT, output, 1: high while in EDIT state.
- FIELD, output, $clog2(NUM_FIELDS) (min 1): field cursor; valid while EDIT=1, otherwise 0.
- INC, output, 1: 1-cycle pulse; increment the selected field.
- DEC, output, 1: 1-cycle pulse; decrement the selected field.
- COMMIT, output, 1: 1-cycle pulse; write the edited value.
- ABORT, output, 1: 1-cycle pulse; discard the edit.
- ALARM_OFF, output, 1: 1-cycle pulse; silence the alarm.
- MERIDIAN_TOGGLE, output, 1: 1-cycle pulse; the meridian flipped.
- out_MERIDIAN, output, 8: ASCII meridian indicator. 8'h41 'A' = AM, 8'h50 'P' = PM.

Behaviour:
Reset:
- RESETN=0 asynchronously clears all registers: MODE=0, EDIT=0, FIELD=0, all pulses 0, out_MERIDIAN=8'h41.
- Repeat, timeout and key-history counters are cleared.
- Reset during EDIT or mid-repeat discards the edit silently; no ABORT pulse.

Key edge detection:
- KEY_q registers KEY every cycle; press = KEY & ~KEY_q.
- A press is valid only when exactly one mapped bit rises and no other mapped bit is held.
- Multi-key presses are ignored entirely, including any repeat.

Latency and pulse rules:
- All outputs are registered.
- A response pulse is high for exactly one cycle, in the cycle after the clock edge that first samples the key high.
- Holding any key other than UP/DOWN generates no further action.

Alarm priority:
- If ALARM_RING=1 when a valid press occurs, only ALARM_OFF pulses.
- The press is consumed: no state change and no other pulse.

VIEW state (EDIT=0):
- MENU: MODE <= MODE+1, wrapping from NUM_MODES-1 to 0.
- SET: enter EDIT with FIELD=0; timeout counter loaded.
- CANCEL with MODE=0: out_MERIDIAN toggles 'A'<->'P' and MERIDIAN_TOGGLE pulses.
- CANCEL with MODE≠0: no action.
- UP/DOWN: ignored.

EDIT state (EDIT=1):
- SET with FIELD<NUM_FIELDS-1: FIELD <= FIELD+1.
- SET with FIELD=NUM_FIELDS-1: COMMIT pulses; return to VIEW with FIELD=0; MODE unchanged.
- CANCEL: ABORT pulses; return to VIEW with FIELD=0.
- MENU: ignored; MODE is frozen in EDIT.
- UP press: INC pulses. DOWN press: DEC pulses.
- Auto-repeat:
  - While UP or DOWN stays held alone, a hold counter runs.
  - The first repeat pulse comes REPEAT_DLY cycles after the initial pulse.
  - Further pulses follow every REPEAT_RATE cycles.
  - Release, or any other key becoming active, stops the repeat and clears the counter.
  - Repeat never fires in VIEW.
- Timeout:
  - Any valid press or repeat pulse reloads the counter.
  - After TIMEOUT cycles with neither, ABORT pulses and the block returns to VIEW.
  - Timeout and COMMIT in the same cycle: COMMIT wins.

Simultaneous events:
- ALARM_RING rising during EDIT does not abort the edit; only the next press is consumed as ALARM_OFF.
- Repeat pulses are suppressed while ALARM_RING=1.

Test Plan:
(Bench parameters: REPEAT_DLY=8, REPEAT_RATE=4, TIMEOUT=50.)
1. Reset, then press MENU 5 times, one press per 3 cycles → MODE steps 1,2,3,0,1; no pulses; out_MERIDIAN=8'h41 throughout.
2. MODE=0, press CANCEL twice → out_MERIDIAN 8'h41 → 8'h50 → 8'h41; one MERIDIAN_TOGGLE pulse per press, one cycle after the sampled edge.
3. Press SET, UP, SET, DOWN, SET, SET → EDIT=1; FIELD 0,1,2; one INC then one DEC pulse; COMMIT on the 4th SET; EDIT=0, FIELD=0.
4. In EDIT, hold UP for 30 cycles → INC at cycles 1, 9, 13, 17, 21, 25, 29 relative to the first pulse (7 pulses total); none after release.
5. Enter EDIT, idle 50 cycles → ABORT pulses exactly once at idle cycle 50; EDIT=0. Then press MENU+SET together → no change.
6. In EDIT with FIELD=1, raise ALARM_RING and press SET → ALARM_OFF pulses; FIELD stays 1. Then assert RESETN=0 mid-UP-hold → all outputs 0 and out_MERIDIAN=8'h41 immediately, with no clock needed.
